// File: rtl/or1k_bpred_pkg.sv
// or1k_bpred_pkg: shared 2-bit counter encodings, controller states and the saturating update rule
package or1k_bpred_pkg;
   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_WT  = 2'b10;
   localparam logic [1:0] CNT_ST  = 2'b11;

   typedef enum logic [1:0] {INIT, IDLE, UPD_RD, UPD_WR} bpred_state_e;

   function automatic logic [1:0] cnt_next(input logic [1:0] s, input logic taken);
      return taken ? (s == CNT_ST ? CNT_ST : s + 2'd1) : (s == CNT_SNT ? CNT_SNT : s - 2'd1);
   endfunction
endpackage

// File: rtl/or1k_bpred_upd_fifo.sv
// or1k_bpred_upd_fifo: queue of resolved branches {idx, taken}; a push into a full queue
// is accepted only when a pop happens in the same cycle.
module or1k_bpred_upd_fifo #(
   parameter int W     = 11,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign dout    = mem[rp];

   always_ff @(posedge clk)
      if (do_push) mem[wp] <= din;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop) rp <= rp + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/or1k_branch_predictor_ctrl.sv
// or1k_branch_predictor_ctrl: gshare PHT port arbiter and update sequencer.
// OR1K_BPRED_INIT_SWEEP_EN enables the post-reset sweep writing weakly-taken to every entry.
module or1k_branch_predictor_ctrl
   import or1k_bpred_pkg::*;
#(
   parameter int GSHARE_BITS_NUM      = 10,
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int UPD_FIFO_DEPTH       = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            lookup_req_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] lookup_pc_i,
   output logic                            lookup_gnt_o,
   output logic [GSHARE_BITS_NUM-1:0]      lookup_idx_o,
   output logic                            ready_o,
   input  logic                            resolve_valid_i,
   input  logic [GSHARE_BITS_NUM-1:0]      resolve_idx_i,
   input  logic                            resolve_taken_i,
   output logic                            pht_en_o,
   output logic                            pht_we_o,
   output logic [GSHARE_BITS_NUM-1:0]      pht_addr_o,
   output logic [1:0]                      pht_wdata_o,
   input  logic [1:0]                      pht_rdata_i,
   output logic [GSHARE_BITS_NUM-1:0]      ghr_o,
   output logic                            upd_full_o,
   output logic [7:0]                      drop_cnt_o
);
   localparam int G = GSHARE_BITS_NUM;
`ifdef OR1K_BPRED_INIT_SWEEP_EN
   localparam bpred_state_e RST_STATE = INIT;
`else
   localparam bpred_state_e RST_STATE = IDLE;
`endif

   bpred_state_e state, state_nxt;
   logic [G-1:0] ghr, upd_idx, head_idx, addr;
   logic         upd_taken, head_taken, q_full, q_empty, pop, gnt, en, we;
   logic [1:0]   upd_val, wdata;
   logic [7:0]   drop_cnt;
   logic         pc_unused;

   assign pc_unused    = ^{lookup_pc_i[OPTION_OPERAND_WIDTH-1:G+2], lookup_pc_i[1:0]};
   assign lookup_idx_o = ghr ^ lookup_pc_i[G+1:2];
   assign ghr_o        = ghr;
   assign drop_cnt_o   = drop_cnt;
   assign upd_full_o   = q_full;
   assign ready_o      = state != INIT;
   // port strobes are forced low while reset is held so an in-flight write is abandoned at once
   assign lookup_gnt_o = gnt & rst;
   assign pht_en_o     = en & rst;
   assign pht_we_o     = we & rst;
   assign pht_addr_o   = addr;
   assign pht_wdata_o  = wdata;

   or1k_bpred_upd_fifo #(.W(G + 1), .DEPTH(UPD_FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (resolve_valid_i),
      .pop   (pop),
      .din   ({resolve_idx_i, resolve_taken_i}),
      .dout  ({head_idx, head_taken}),
      .full  (q_full),
      .empty (q_empty)
   );

`ifdef OR1K_BPRED_INIT_SWEEP_EN
   logic [G-1:0] init_cnt;

   always_ff @(posedge clk or negedge rst)
      if (!rst) init_cnt <= '0;
      else if (state == INIT) init_cnt <= init_cnt + G'(1);
`endif

   always_comb begin
      state_nxt = state;
      gnt       = 1'b0;
      en        = 1'b0;
      we        = 1'b0;
      pop       = 1'b0;
      addr      = lookup_idx_o;
      wdata     = upd_val;
      case (state)
`ifdef OR1K_BPRED_INIT_SWEEP_EN
         INIT: begin
            en    = 1'b1;
            we    = 1'b1;
            addr  = init_cnt;
            wdata = CNT_WT;
            if (&init_cnt) state_nxt = IDLE;
         end
`endif
         IDLE: begin
            // a full queue takes the port so updates progress under a continuous lookup stream
            if (lookup_req_i && !q_full) begin
               gnt = 1'b1;
               en  = 1'b1;
            end else if (!q_empty) begin
               pop       = 1'b1;
               en        = 1'b1;
               addr      = head_idx;
               state_nxt = UPD_RD;
            end
         end
         UPD_RD: state_nxt = UPD_WR;
         UPD_WR: begin
            en        = 1'b1;
            we        = 1'b1;
            addr      = upd_idx;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RST_STATE;
         ghr       <= '0;
         drop_cnt  <= '0;
         upd_idx   <= '0;
         upd_taken <= 1'b0;
         upd_val   <= CNT_WT;
      end else begin
         state <= state_nxt;
         if (resolve_valid_i) ghr <= {ghr[G-2:0], resolve_taken_i};
         if (resolve_valid_i && q_full && !pop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
         if (pop) {upd_idx, upd_taken} <= {head_idx, head_taken};
         if (state == UPD_RD) upd_val <= cnt_next(pht_rdata_i, upd_taken);
      end
   end
endmodule

// File: tb/tb_or1k_branch_predictor_ctrl.sv
// tb_or1k_branch_predictor_ctrl: randomized bench with a queue-based reference model and a RAM model;
// honours OR1K_BPRED_INIT_SWEEP_EN the same way as the design.
module tb_or1k_branch_predictor_ctrl;
   localparam int G = 4;
   localparam int D = 4;

   typedef struct {
      logic [3:0] idx;
      logic       t;
   } ent_t;

   logic        clk = 1'b0, rst = 1'b0;
   logic        lookup_req_i = 1'b0, resolve_valid_i = 1'b0, resolve_taken_i = 1'b0;
   logic [31:0] lookup_pc_i = '0;
   logic [3:0]  resolve_idx_i = '0;
   logic [1:0]  pht_rdata_i = '0;
   logic        lookup_gnt_o, ready_o, pht_en_o, pht_we_o, upd_full_o;
   logic [3:0]  lookup_idx_o, pht_addr_o, ghr_o;
   logic [1:0]  pht_wdata_o;
   logic [7:0]  drop_cnt_o;

   logic [1:0]  mem [16];
   logic [3:0]  last_waddr = '0;
   logic [1:0]  last_wdata = '0;

   int          n_cmp = 0, n_err = 0;
   ent_t        q[$];
   ent_t        m_cur;
   logic [3:0]  m_ghr;
   logic [1:0]  tab [16];
   int          m_drop, m_phase, m_iaddr;
   bit          m_init, pend;
   logic [1:0]  pend_v;
`ifdef OR1K_BPRED_INIT_SWEEP_EN
   localparam bit SWEEP = 1'b1;
`else
   localparam bit SWEEP = 1'b0;
`endif

   always #5 clk = ~clk;

   or1k_branch_predictor_ctrl #(
      .GSHARE_BITS_NUM(G), .OPTION_OPERAND_WIDTH(32), .UPD_FIFO_DEPTH(D)
   ) dut (
      .clk(clk), .rst(rst),
      .lookup_req_i(lookup_req_i), .lookup_pc_i(lookup_pc_i), .lookup_gnt_o(lookup_gnt_o),
      .lookup_idx_o(lookup_idx_o), .ready_o(ready_o),
      .resolve_valid_i(resolve_valid_i), .resolve_idx_i(resolve_idx_i), .resolve_taken_i(resolve_taken_i),
      .pht_en_o(pht_en_o), .pht_we_o(pht_we_o), .pht_addr_o(pht_addr_o), .pht_wdata_o(pht_wdata_o),
      .pht_rdata_i(pht_rdata_i), .ghr_o(ghr_o), .upd_full_o(upd_full_o), .drop_cnt_o(drop_cnt_o)
   );

   always @(posedge clk)
      if (pht_en_o) begin
         if (pht_we_o) begin
            mem[pht_addr_o] <= pht_wdata_o;
            last_waddr      <= pht_addr_o;
            last_wdata      <= pht_wdata_o;
         end else pht_rdata_i <= mem[pht_addr_o];
      end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] sat(input logic [1:0] s, input logic t);
      int v;
      v = t ? int'(s) + 1 : int'(s) - 1;
      if (v > 3) v = 3;
      if (v < 0) v = 0;
      return 2'(v);
   endfunction

   task automatic model_reset();
      q.delete();
      m_ghr   = '0;
      m_drop  = 0;
      m_phase = 0;
      m_iaddr = 0;
      m_init  = SWEEP;
      pend    = 1'b0;
   endtask

   // one clock cycle: drive at posedge+1, compare mid-cycle, advance the model at the edge
   task automatic cyc(input bit req, input logic [31:0] pc, input bit rv, input logic [3:0] ri, input bit rt);
      bit         e_gnt, e_en, e_we, e_pop;
      logic [3:0] e_addr, e_lidx;
      logic [1:0] e_wd;
      lookup_req_i    = req;
      lookup_pc_i     = pc;
      resolve_valid_i = rv;
      resolve_idx_i   = ri;
      resolve_taken_i = rt;
      #3;
      e_gnt = 0; e_en = 0; e_we = 0; e_pop = 0; e_addr = '0; e_wd = '0;
      e_lidx = m_ghr ^ pc[5:2];
      if (m_init) begin
         e_en = 1; e_we = 1; e_addr = 4'(m_iaddr); e_wd = 2'b10;
      end else if (m_phase == 2) begin
         e_en = 1; e_we = 1; e_addr = m_cur.idx; e_wd = sat(tab[m_cur.idx], m_cur.t);
      end else if (m_phase == 0) begin
         if (req && q.size() != D) begin
            e_gnt = 1; e_en = 1; e_addr = e_lidx;
         end else if (q.size() > 0) begin
            e_pop = 1; e_en = 1; e_addr = q[0].idx;
         end
      end
      chk("gnt", 32'(lookup_gnt_o), 32'(e_gnt));
      chk("en", 32'(pht_en_o), 32'(e_en));
      chk("we", 32'(pht_we_o), 32'(e_we));
      if (e_en) chk("addr", 32'(pht_addr_o), 32'(e_addr));
      if (e_we) chk("wdata", 32'(pht_wdata_o), 32'(e_wd));
      chk("idx", 32'(lookup_idx_o), 32'(e_lidx));
      chk("ghr", 32'(ghr_o), 32'(m_ghr));
      chk("full", 32'(upd_full_o), 32'(q.size() == D));
      chk("drop", 32'(drop_cnt_o), 32'(m_drop));
      chk("ready", 32'(ready_o), 32'(!m_init));
      if (pend) chk("pred", 32'(pht_rdata_i), 32'(pend_v));
      @(posedge clk);
      pend   = e_gnt;
      pend_v = tab[e_addr];
      if (m_init) begin
         tab[m_iaddr] = 2'b10;
         if (m_iaddr == 15) m_init = 0;
         else m_iaddr++;
      end else if (m_phase == 2) begin
         tab[m_cur.idx] = e_wd;
         m_phase = 0;
      end else if (m_phase == 1) m_phase = 2;
      else if (e_pop) begin
         m_cur   = q.pop_front();
         m_phase = 1;
      end
      if (rv) begin
         if (q.size() < D) q.push_back('{ri, rt});
         else if (m_drop < 255) m_drop++;
         m_ghr = {m_ghr[2:0], rt};
      end
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, $urandom, 0, 4'd0, 0);
   endtask

   task automatic run_upd(input logic [3:0] idx, input bit t, input logic [1:0] pre, input logic [1:0] expw);
      mem[idx] <= pre;
      tab[idx] = pre;
      cyc(0, 0, 1, idx, t);
      idle(3);
      chk("upd_addr", 32'(last_waddr), 32'(idx));
      chk("upd_data", 32'(last_wdata), 32'(expw));
   endtask

   initial begin
      logic [1:0] v;
      for (int i = 0; i < 16; i++) begin
         v = 2'($urandom_range(0, 3));
         mem[i] <= v;
         tab[i] = v;
      end
      #12;
      chk("rst_gnt", 32'(lookup_gnt_o), 0);
      chk("rst_en", 32'(pht_en_o), 0);
      chk("rst_we", 32'(pht_we_o), 0);
      chk("rst_ghr", 32'(ghr_o), 0);
      chk("rst_drop", 32'(drop_cnt_o), 0);
      chk("rst_ready", 32'(ready_o), 32'(!SWEEP));
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
`ifdef OR1K_BPRED_INIT_SWEEP_EN
      #1;
      chk("init_addr0", 32'(pht_addr_o), 0);
      chk("init_wd0", 32'(pht_wdata_o), 2);
      repeat (16) cyc(1, $urandom, 0, 4'd0, 0);
      chk("init_ready", 32'(ready_o), 1);
`endif
      lookup_pc_i = 32'h44;
      #1;
      chk("idx_44_g0", 32'(lookup_idx_o), 1);
      cyc(0, 32'h44, 1, 4'd0, 1);
      chk("ghr_after_t", 32'(ghr_o), 1);
      chk("idx_44_g1", 32'(lookup_idx_o), 0);
      idle(8);
      run_upd(4'd3, 1, 2'b11, 2'b11);
      run_upd(4'd5, 0, 2'b00, 2'b00);
      run_upd(4'd7, 1, 2'b01, 2'b10);
      idle(8);
      repeat (4) cyc(1, $urandom, 1, 4'($urandom_range(0, 15)), 1'($urandom));
      lookup_req_i = 1'b1;
      #1;
      chk("full_lit", 32'(upd_full_o), 1);
      chk("full_gnt", 32'(lookup_gnt_o), 0);
      cyc(1, $urandom, 1, 4'd9, 1);
      cyc(1, $urandom, 1, 4'd10, 0);
      chk("drop_lit", 32'(drop_cnt_o), 1);
      idle(20);
      cyc(0, $urandom, 1, 4'd2, 1);
      lookup_req_i = 1'b1;
      #1;
      chk("nonfull_gnt", 32'(lookup_gnt_o), 1);
      cyc(1, $urandom, 0, 4'd0, 0);
      lookup_req_i = 1'b0;
      #1;
      chk("serve_en", 32'(pht_en_o), 1);
      chk("serve_gnt", 32'(lookup_gnt_o), 0);
      idle(6);
      for (int b = 0; b < 6; b++) begin
         int rp, vp;
         rp = (b % 3) * 40 + 15;
         vp = 20 + b * 13;
         repeat (500)
            cyc($urandom_range(0, 99) < rp, $urandom, $urandom_range(0, 99) < vp,
                4'($urandom_range(0, 15)), 1'($urandom));
      end
      idle(12);
      cyc(0, $urandom, 1, 4'd5, 1);
      idle(2);
      #2;
      chk("wr_before_rst", 32'(pht_we_o), 1);
      rst = 1'b0;
      #1;
      chk("rst_we_drop", 32'(pht_we_o), 0);
      chk("rst_en_drop", 32'(pht_en_o), 0);
      chk("rst_ghr_clr", 32'(ghr_o), 0);
      chk("rst_full_clr", 32'(upd_full_o), 0);
      chk("rst_drop_clr", 32'(drop_cnt_o), 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
`ifdef OR1K_BPRED_INIT_SWEEP_EN
      #1;
      chk("reinit_addr0", 32'(pht_addr_o), 0);
      chk("reinit_we", 32'(pht_we_o), 1);
`endif
      repeat (300)
         cyc($urandom_range(0, 1), $urandom, $urandom_range(0, 2) == 0,
             4'($urandom_range(0, 15)), 1'($urandom));
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/or1k_branch_predictor_ctrl.md
# or1k_branch_predictor_ctrl

Sequencer and port arbiter for a gshare pattern-history table (PHT) held in a single-port synchronous RAM. It sits between the fetch/decode lookup path and the execute-stage branch resolution path. It initialises the PHT after reset, forms gshare indices from the global history register (GHR), and grants the one RAM port either to predictions or to queued 2-bit counter updates. Updates are queued and applied as read-modify-write.

## Interface
- GSHARE_BITS_NUM, 10, index/GHR width G; PHT has 2^G entries
- OPTION_OPERAND_WIDTH, 32, PC width
- UPD_FIFO_DEPTH, 4, resolved-branch queue depth (power of 2, ≥2)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- lookup_req_i  in  1  decode requests a prediction read
- lookup_pc_i  in  OPTION_OPERAND_WIDTH  PC of the conditional branch
- lookup_gnt_o  out  1  PHT read issued this cycle
- lookup_idx_o  out  G  index used; fetch stores it for resolve
- ready_o  out  1  initialisation finished
- resolve_valid_i  in  1  one conditional branch resolved
- resolve_idx_i  in  G  index returned from lookup
- resolve_taken_i  in  1  actual direction
- pht_en_o  out  1  RAM access enable
- pht_we_o  out  1  RAM write enable
- pht_addr_o  out  G  RAM address
- pht_wdata_o  out  2  RAM write data
- pht_rdata_i  in  2  RAM read data, valid the cycle after a read
- ghr_o  out  G  global history
- upd_full_o  out  1  update queue full
- drop_cnt_o  out  8  saturating count of dropped resolves

## Operation
- Index calculation: lookup_idx_o = ghr ^ lookup_pc_i[G+1:2]. This is combinational from the current GHR.
- GHR update: on every resolve_valid_i, ghr <= {ghr[G-2:0], resolve_taken_i}. This happens whether or not the entry is queued.
- Queue push: on resolve_valid_i, push {resolve_idx_i, resolve_taken_i}.
  - If the queue is full and not popping this cycle, the entry is dropped and drop_cnt_o increments, saturating at 255.
  - If the queue is full and popping this cycle, the push is accepted.
- FSM states: INIT, IDLE, UPD_RD, UPD_WR.
- INIT:
  - Writes 2'b10 (weakly taken) to address init_cnt.
  - init_cnt counts 0..2^G-1.
  - After the last address, go to IDLE.
  - lookup_gnt_o = 0. Queue pushes are still accepted.
- IDLE arbitration:
  - lookup_req_i wins unless upd_full_o = 1.
  - On a lookup win: gnt = 1, en = 1, we = 0, addr = lookup_idx_o; stay in IDLE.
  - Otherwise, if the queue is non-empty: pop the head, issue a read of its idx, go to UPD_RD.
- UPD_RD:
  - Port is idle; gnt = 0.
  - Capture pht_rdata_i, compute the next counter value, go to UPD_WR.
- UPD_WR:
  - we = 1, addr = captured idx, wdata = saturated value; gnt = 0; go to IDLE.
- Counter arithmetic: taken gives min(s+1, 3); not-taken gives max(s-1, 0). Values are unsigned 2-bit.
- Back-to-back lookup and write to the same index need no bypass: the port serialises them, so a lookup after UPD_WR reads the updated value.

## Timing
- Reset values:
  - State = INIT (with macro) or IDLE (without).
  - ghr = 0, queue empty, drop_cnt_o = 0, init_cnt = 0.
  - ready_o = 0 (with macro) or 1 (without).
  - lookup_gnt_o, pht_en_o and pht_we_o are 0 while rst is low.
- Init latency: 2^G cycles of writes. ready_o rises in the cycle after the last write.
- Lookup latency: gnt is combinational in the request cycle. The prediction (pht_rdata_i) is valid in the next cycle.
- Update service: 3 cycles from pop to write-complete (IDLE read, UPD_RD, UPD_WR). The port is busy for 2 of those cycles.
- upd_full_o is registered from the queue count. Within the full-queue condition, update priority guarantees forward progress under a continuous lookup stream.
- Reset asserted mid-operation (any state) clears everything asynchronously. A write in flight is abandoned and pht_we_o drops immediately.

## Configuration
- OR1K_BPRED_INIT_SWEEP_EN
  - Defined: INIT state and init_cnt exist; behaviour as above.
  - Undefined: no INIT state; reset goes straight to IDLE with ready_o = 1, and PHT contents are whatever the RAM holds.

## Structure
- Package or1k_bpred_pkg holds:
  - The 2-bit counter state constants (00/01/10/11 = strongly NT, weakly NT, weakly T, strongly T).
  - The controller FSM state enum.
  - A function computing the saturating counter update.
- Sub-module or1k_bpred_upd_fifo: synchronous FIFO of {idx, taken}, with count, full, empty, and same-cycle push/pop.

## Test plan
All scenarios use G = 4 and depth 4.
- Reset, macro on → pht writes addr 0..15 with wdata 2'b10; ready_o = 1 at cycle 16; lookup_gnt_o = 0 throughout init.
- ghr = 0, lookup_pc_i = 0x44 → lookup_idx_o = 1; then resolve taken → ghr = 1 and the same PC gives idx 0.
- Resolve idx 3 taken, pht_rdata_i = 2'b11 → UPD_WR writes 3/2'b11. Resolve idx 5 not-taken, rdata 2'b00 → writes 2'b00. Resolve taken, rdata 2'b01 → writes 2'b10.
- lookup_req_i held high, 4 resolves → queue full, next IDLE cycle pops (gnt = 0). A 5th resolve while full and not popping → drop_cnt_o = 1.
- Lookup request with a non-full, non-empty queue → lookup granted, queue unchanged; lookup deasserted → update served.
- rst low during UPD_WR → pht_we_o = 0 immediately, queue empty, ghr = 0; after release, init restarts at addr 0.
